key_expansion: RTL
==================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request to expand key_in; SHALL be sampled only in IDLE or DONE.
REQ-005 key_in  input  128  AES-128 cipher key; byte 0 (FIPS-197 order) SHALL be on bits [127:120]; SHALL be sampled on the accepted start cycle only.
REQ-006 busy  output  1  high while an expansion is in progress.
REQ-007 done  output  1  high while all 11 round keys are valid.
REQ-008 rd_round  input  4  round-key index, 0..10.
REQ-009 rd_key  output  128  round key selected by rd_round, in the same byte order as key_in.

Function
REQ-010 The FSM SHALL have three states: IDLE, EXPAND and DONE.
REQ-011 IDLE or DONE with start=1 SHALL capture key_in as round key 0, set the round counter to 1, and move to EXPAND.
REQ-012 EXPAND SHALL produce one round key per cycle: key[r] = f(key[r-1], Rcon[r]), using RotWord, then SubWord, then Rcon XOR on word 3, followed by the chained word XORs of FIPS-197.
REQ-013 SubWord SHALL use the codebase S-box function, with 4 instances, combinationally.
REQ-014 The Rcon sequence for r=1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 in the MS byte; the other bytes SHALL be 0.
REQ-015 After writing round 10 the FSM SHALL go to DONE, so DONE is entered on the 10th clock edge after the start edge.
REQ-016 busy SHALL be 1 exactly in EXPAND; done SHALL be 1 exactly in DONE; they SHALL never both be 1.
REQ-017 start while in EXPAND SHALL be ignored, with no restart and no key capture.
REQ-018 start while in DONE SHALL restart: done drops on the next edge, and storage is overwritten round by round.
REQ-019 Storage SHALL be an 11 x 128 register array, written only by the FSM.
REQ-020 rd_round > 10 SHALL yield rd_key = 0.
REQ-021 rd_key for a round not yet written in the current expansion SHALL return the stored (stale) value; only done=1 guarantees a consistent key set.
REQ-022 The round counter SHALL be 4 bits, SHALL never exceed 10, and SHALL NOT wrap.

Reset
REQ-023 rst=1 SHALL force IDLE, busy=0, done=0, round counter=0 and all 11 stored keys=0, on the next clock edge.
REQ-024 rst SHALL take priority over start; rst during EXPAND SHALL abort the expansion, with no partial done.
REQ-025 With storage zeroed, rd_key SHALL read 0 for every rd_round after reset.

Configuration
REQ-026 The macro AES_KEYEXP_REG_OUT_EN SHALL select the read-port timing.
REQ-027 With AES_KEYEXP_REG_OUT_EN defined, rd_key SHALL be registered: it reflects rd_round sampled one cycle earlier, and it resets to 0.
REQ-028 Without AES_KEYEXP_REG_OUT_EN, rd_key SHALL be a combinational mux of rd_round with zero-cycle latency.
REQ-029 All other behaviour SHALL be identical in both builds.

Verification
REQ-030 The bench SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c with start -> busy for 10 cycles, then done=1; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 0 = key_in.
REQ-031 The bench SHALL cover: key all-zero -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032 The bench SHALL cover: start pulsed with a different key at cycle 4 of EXPAND -> ignored; the final keys match the first key only.
REQ-033 The bench SHALL cover: rst asserted at cycle 5 of EXPAND -> next edge busy=0, done=0; rd_key=0 for rounds 0..10; a later start completes normally.
REQ-034 The bench SHALL cover: in DONE, start with the zero key -> done=0 for 10 cycles, then the REQ-031 values are present.
REQ-035 The bench SHALL cover: rd_round=11..15 -> rd_key=0; with AES_KEYEXP_REG_OUT_EN, every rd_key check is delayed by exactly 1 cycle.

Source files
------------

// File: rtl/key_expansion.sv
// AES-128 key expansion: one round key per cycle into an 11 x 128 register file.
// Define AES_KEYEXP_REG_OUT_EN to register the rd_key read port (one cycle latency).
module key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_round,
  output logic         busy,
  output logic         done,
  output logic [127:0] rd_key,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         r_state;
  state_t         w_next_state;
  logic [3:0]     r_round;
  logic [127:0]   r_keys [0:10];
  logic [127:0]   r_last;       // copy of the most recently written key, avoids a read mux
  logic           w_capture;
  logic           w_write;

  logic [31:0]    w_w0, w_w1, w_w2, w_w3;
  logic [31:0]    w_rot, w_sub, w_temp;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;
  logic [127:0]   w_next_key;
  logic [127:0]   w_rd_sel;

  // Next state and control; start is only honoured in IDLE or DONE.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_next_state = S_EXPAND;
        end
      end
      S_EXPAND: begin
        w_write = 1'b1;
        if (r_round == 4'd10) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  assign busy        = (r_state == S_EXPAND);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

  // One FIPS-197 schedule step from the previous round key.
  assign w_w0  = r_last[127:96];
  assign w_w1  = r_last[95:64];
  assign w_w2  = r_last[63:32];
  assign w_w3  = r_last[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
  end

  assign w_temp     = w_sub ^ {rcon(r_round), 24'h000000};
  assign w_n0       = w_w0 ^ w_temp;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round <= 4'd0;
      r_last  <= '0;
      for (int i = 0; i < 11; i++) r_keys[i] <= '0;
    end else if (w_capture) begin
      r_round   <= 4'd1;
      r_last    <= key_in;
      r_keys[0] <= key_in;
    end else if (w_write) begin
      r_keys[r_round] <= w_next_key;
      r_last          <= w_next_key;
      if (r_round != 4'd10) r_round <= r_round + 4'd1;
    end
  end

  assign w_rd_sel = (rd_round <= 4'd10) ? r_keys[rd_round] : '0;

`ifdef AES_KEYEXP_REG_OUT_EN
  logic [127:0] r_rd_key;

  always_ff @(posedge clk) begin
    if (rst) r_rd_key <= '0;
    else     r_rd_key <= w_rd_sel;
  end

  assign rd_key = r_rd_key;
`else
  assign rd_key = w_rd_sel;
`endif

endmodule
